// File: rtl/timer_pkg.sv
// Shared types and constants for the run/pause/clear one-second timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] MAX_SEC = 4'd9;

    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] value);
        if (value > MAX_SEC) begin
            return MAX_SEC;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/timer_ctrl_tick_gen.sv
// Two-stage prescaler: pre divides by PRE_DIV, sub by SUB_DIV; tick marks the
// last cycle of each full PRE_DIV*SUB_DIV period while enabled.
module m_tick_gen #(
    parameter int PRE_DIV = 50000,
    parameter int SUB_DIV = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PRE_W = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam int SUB_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_DIV - 1);

    logic [PRE_W-1:0] pre_r;
    logic [SUB_W-1:0] sub_r;
    logic             pre_wrap_s;
    logic             sub_wrap_s;

    assign pre_wrap_s = (pre_r == PRE_LAST);
    assign sub_wrap_s = (sub_r == SUB_LAST);
    assign tick       = en && pre_wrap_s && sub_wrap_s;

    // Prescaler chain; clr beats en, and with neither the phase is frozen.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pre_r <= {PRE_W{1'b0}};
            sub_r <= {SUB_W{1'b0}};
        end else if (en) begin
            if (pre_wrap_s) begin
                pre_r <= {PRE_W{1'b0}};
                sub_r <= sub_wrap_s ? {SUB_W{1'b0}} : sub_r + SUB_W'(1);
            end else begin
                pre_r <= pre_r + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Run/pause/clear controller: FSM gating the prescaler, a 0..9 digit counting
// toward a preset latched at launch, and a one-hot seconds decode.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int PRE_DIV = 50000,
    parameter int SUB_DIV = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               clear,
    input  logic               mode_up,
    input  logic [DIGIT_W-1:0] preset,
    output logic [DIGIT_W-1:0] cnt,
    output logic [9:0]         sec,
    output logic               running,
    output logic               done,
    output logic               tick
);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [DIGIT_W-1:0] cnt_r;
    logic [DIGIT_W-1:0] target_r;
    logic [DIGIT_W-1:0] clamp_s;
    logic               mode_up_r;
    logic               launch_s;
    logic               at_end_s;
    logic               pre_en_s;
    logic               pre_clr_s;
    logic               tick_s;

    assign clamp_s   = clamp_digit(preset);
    assign pre_en_s  = (state_r == RUN);
    assign pre_clr_s = clear || launch_s || (state_r == IDLE) || (state_r == DONE);

    m_tick_gen #(
        .PRE_DIV (PRE_DIV),
        .SUB_DIV (SUB_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (pre_en_s),
        .clr  (pre_clr_s),
        .tick (tick_s)
    );

    // The step about to happen lands on the terminal value for this direction.
    always_comb begin
        if (mode_up_r) begin
            at_end_s = ((cnt_r + DIGIT_W'(1)) == target_r);
        end else begin
            at_end_s = (cnt_r == DIGIT_W'(1));
        end
    end

    // Next-state logic; clear outranks start in every state.
    always_comb begin
        state_nxt_s = state_r;
        launch_s    = 1'b0;
        if (clear) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        launch_s    = 1'b1;
                        state_nxt_s = (clamp_s == {DIGIT_W{1'b0}}) ? DONE : RUN;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                RUN: begin
                    if (tick_s && at_end_s) begin
                        state_nxt_s = DONE;
                    end else if (start) begin
                        state_nxt_s = PAUSE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = PAUSE;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Digit register plus the target and direction captured at launch.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= {DIGIT_W{1'b0}};
            target_r  <= {DIGIT_W{1'b0}};
            mode_up_r <= 1'b0;
        end else if (clear) begin
            cnt_r <= {DIGIT_W{1'b0}};
        end else if (launch_s) begin
            target_r  <= clamp_s;
            mode_up_r <= mode_up;
            cnt_r     <= mode_up ? {DIGIT_W{1'b0}} : clamp_s;
        end else if ((state_r == RUN) && tick_s) begin
            cnt_r <= mode_up_r ? cnt_r + DIGIT_W'(1) : cnt_r - DIGIT_W'(1);
        end
    end

    assign cnt     = cnt_r;
    assign sec     = 10'd1 << cnt_r;
    assign running = (state_r == RUN);
    assign done    = (state_r == DONE);
    assign tick    = tick_s;

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl with a 12-cycle second (PRE_DIV=4, SUB_DIV=3).
module tb_timer_ctrl;

    typedef struct {
        int         cyc;
        logic [3:0] cnt;
        logic       done;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       clear;
    logic       mode_up;
    logic [3:0] preset;
    logic [3:0] cnt;
    logic [9:0] sec;
    logic       running;
    logic       done;
    logic       tick;

    int         total;
    int         bad;
    int         cyc;
    exp_t       sb[$];
    logic       chk_pend;
    logic [3:0] exp_cnt;
    logic       exp_done;

    timer_ctrl #(.PRE_DIV(4), .SUB_DIV(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .clear   (clear),
        .mode_up (mode_up),
        .preset  (preset),
        .cnt     (cnt),
        .sec     (sec),
        .running (running),
        .done    (done),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; clear = 1'b0; mode_up = 1'b0; preset = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0; start = 1'b0;
        total++;
        if (cnt !== 4'd0 || sec !== 10'h001) begin
            bad++; $display("FAIL reset_cnt: cnt=%0d sec=%h, want cnt=0 sec=001", cnt, sec);
        end
        total++;
        if (running !== 1'b0 || done !== 1'b0 || tick !== 1'b0) begin
            bad++; $display("FAIL reset_flags: running=%b done=%b tick=%b, want 000", running, done, tick);
        end
        @(negedge clk);
        total++;
        if (running !== 1'b0) begin
            bad++; $display("FAIL reset_start_ignored: running=%b, want 0", running);
        end
    endtask

    task automatic test_up_count();
        int   c0;
        exp_t e;
        @(negedge clk);
        mode_up = 1'b1; preset = 4'd3; start = 1'b1; c0 = cyc;
        for (int k = 1; k <= 3; k++) sb.push_back('{c0 + 12 * k, 4'(k), (k == 3)});
        @(negedge clk);
        start = 1'b0;
        total++;
        if (running !== 1'b1) begin
            bad++; $display("FAIL up_running: running=%b, want 1", running);
        end
        chk_pend = 1'b0;
        while (cyc < c0 + 50) begin
            @(negedge clk);
            if (chk_pend) begin
                chk_pend = 1'b0; total++;
                if (cnt !== exp_cnt || done !== exp_done) begin
                    bad++; $display("FAIL up_step: cnt=%0d done=%b, want cnt=%0d done=%b", cnt, done, exp_cnt, exp_done);
                end
            end
            if (tick !== 1'b0) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL up_tick: tick=%b at cycle %0d, want none", tick, cyc - c0);
                end else begin
                    e = sb.pop_front();
                    if (cyc != e.cyc) begin
                        bad++; $display("FAIL up_tick: tick at cycle %0d, want %0d", cyc - c0, e.cyc - c0);
                    end
                    exp_cnt = e.cnt; exp_done = e.done; chk_pend = 1'b1;
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL up_missing: %0d ticks outstanding, want 0", sb.size());
        end
        sb.delete();
        total++;
        if (cnt !== 4'd3 || sec !== 10'h008 || done !== 1'b1 || running !== 1'b0) begin
            bad++; $display("FAIL up_final: cnt=%0d sec=%h done=%b running=%b, want 3 008 1 0", cnt, sec, done, running);
        end
    endtask

    task automatic test_down_clamp();
        int   c0;
        exp_t e;
        @(negedge clk);
        mode_up = 1'b0; preset = 4'd12; start = 1'b1; c0 = cyc;
        for (int k = 1; k <= 9; k++) sb.push_back('{c0 + 12 * k, 4'(9 - k), (k == 9)});
        @(negedge clk);
        start = 1'b0;
        total++;
        if (cnt !== 4'd9 || running !== 1'b1) begin
            bad++; $display("FAIL down_load: cnt=%0d running=%b, want cnt=9 running=1", cnt, running);
        end
        chk_pend = 1'b0;
        while (cyc < c0 + 122) begin
            @(negedge clk);
            if (chk_pend) begin
                chk_pend = 1'b0; total++;
                if (cnt !== exp_cnt || done !== exp_done) begin
                    bad++; $display("FAIL down_step: cnt=%0d done=%b, want cnt=%0d done=%b", cnt, done, exp_cnt, exp_done);
                end
            end
            if (tick !== 1'b0) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL down_tick: tick=%b at cycle %0d, want none", tick, cyc - c0);
                end else begin
                    e = sb.pop_front();
                    if (cyc != e.cyc) begin
                        bad++; $display("FAIL down_tick: tick at cycle %0d, want %0d", cyc - c0, e.cyc - c0);
                    end
                    exp_cnt = e.cnt; exp_done = e.done; chk_pend = 1'b1;
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL down_missing: %0d ticks outstanding, want 0", sb.size());
        end
        sb.delete();
        total++;
        if (cnt !== 4'd0 || sec !== 10'h001 || done !== 1'b1) begin
            bad++; $display("FAIL down_final: cnt=%0d sec=%h done=%b, want 0 001 1", cnt, sec, done);
        end
    endtask

    task automatic test_pause_resume();
        int   c0;
        int   r;
        exp_t e;
        @(negedge clk);
        mode_up = 1'b1; preset = 4'd5; start = 1'b1; c0 = cyc;
        // Seven RUN cycles before the pause leave five to finish the second.
        r = c0 + 27;
        for (int k = 1; k <= 5; k++) sb.push_back('{r + 5 + 12 * (k - 1), 4'(k), (k == 5)});
        chk_pend = 1'b0;
        while (cyc < c0 + 95) begin
            @(negedge clk);
            if (chk_pend) begin
                chk_pend = 1'b0; total++;
                if (cnt !== exp_cnt || done !== exp_done) begin
                    bad++; $display("FAIL pause_step: cnt=%0d done=%b, want cnt=%0d done=%b", cnt, done, exp_cnt, exp_done);
                end
            end
            if (tick !== 1'b0) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL pause_tick: tick=%b at cycle %0d, want none", tick, cyc - c0);
                end else begin
                    e = sb.pop_front();
                    if (cyc != e.cyc) begin
                        bad++; $display("FAIL pause_tick: tick at cycle %0d, want %0d", cyc - c0, e.cyc - c0);
                    end
                    exp_cnt = e.cnt; exp_done = e.done; chk_pend = 1'b1;
                end
            end
            if (cyc == c0 + 20) begin
                total++;
                if (cnt !== 4'd0 || running !== 1'b0 || done !== 1'b0) begin
                    bad++; $display("FAIL pause_hold: cnt=%0d running=%b done=%b, want 0 0 0", cnt, running, done);
                end
            end
            start = (cyc == c0 + 7) || (cyc == r);
        end
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL pause_missing: %0d ticks outstanding, want 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_zero_and_simultaneous();
        int c0;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        total++;
        if (done !== 1'b0 || cnt !== 4'd0 || running !== 1'b0) begin
            bad++; $display("FAIL clear_done: done=%b cnt=%0d running=%b, want 0 0 0", done, cnt, running);
        end
        mode_up = 1'b1; preset = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (done !== 1'b1 || running !== 1'b0 || cnt !== 4'd0) begin
            bad++; $display("FAIL zero_preset: done=%b running=%b cnt=%0d, want 1 0 0", done, running, cnt);
        end
        preset = 4'd5; start = 1'b1; c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 15) @(negedge clk);
        total++;
        if (cnt !== 4'd1 || running !== 1'b1) begin
            bad++; $display("FAIL sim_prerun: cnt=%0d running=%b, want 1 1", cnt, running);
        end
        start = 1'b1; clear = 1'b1;
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        total++;
        if (cnt !== 4'd0 || running !== 1'b0 || done !== 1'b0 || tick !== 1'b0) begin
            bad++; $display("FAIL sim_start_clear: cnt=%0d running=%b done=%b tick=%b, want 0 0 0 0", cnt, running, done, tick);
        end
    endtask

    task automatic test_clear_restart();
        int   c0;
        exp_t e;
        @(negedge clk);
        mode_up = 1'b1; preset = 4'd5; start = 1'b1; c0 = cyc;
        sb.push_back('{c0 + 12, 4'd1, 1'b0});
        sb.push_back('{c0 + 24, 4'd2, 1'b0});
        chk_pend = 1'b0;
        while (cyc < c0 + 46) begin
            @(negedge clk);
            if (chk_pend) begin
                chk_pend = 1'b0; total++;
                if (cnt !== exp_cnt || done !== exp_done) begin
                    bad++; $display("FAIL restart_step: cnt=%0d done=%b, want cnt=%0d done=%b", cnt, done, exp_cnt, exp_done);
                end
            end
            if (tick !== 1'b0) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL restart_tick: tick=%b at cycle %0d, want none", tick, cyc - c0);
                end else begin
                    e = sb.pop_front();
                    if (cyc != e.cyc) begin
                        bad++; $display("FAIL restart_tick: tick at cycle %0d, want %0d", cyc - c0, e.cyc - c0);
                    end
                    exp_cnt = e.cnt; exp_done = e.done; chk_pend = 1'b1;
                end
            end
            if (cyc == c0 + 31) begin
                total++;
                if (cnt !== 4'd0 || running !== 1'b0) begin
                    bad++; $display("FAIL restart_cleared: cnt=%0d running=%b, want 0 0", cnt, running);
                end
            end
            clear = (cyc == c0 + 30);
            start = (cyc == c0 + 32);
            if (cyc == c0 + 32) sb.push_back('{cyc + 12, 4'd1, 1'b0});
        end
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL restart_missing: %0d ticks outstanding, want 0", sb.size());
        end
        sb.delete();
    endtask

    initial begin
        total = 0;
        bad = 0;
        chk_pend = 1'b0;
        exp_cnt = 4'd0;
        exp_done = 1'b0;
        test_reset();
        test_up_count();
        test_down_clamp();
        test_pause_resume();
        test_zero_and_simultaneous();
        test_clear_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
